div_unit: RTL and testbench



---
 rtl/div_unit_pkg.sv | 13 +
 rtl/div_step.sv | 25 ++
 rtl/div_unit.sv | 121 ++++++++++++
 tb/tb_div_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage divider: FSM state type and iteration count.
package div_unit_pkg;

  localparam int unsigned DIV_WIDTH  = 32;
  localparam int unsigned DIV_CYCLES = DIV_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             neg;

  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    // One extra bit above the partial remainder exposes the borrow of the trial subtract.
    diff     = shifted - {2'b00, divisor};
    neg      = diff[WIDTH+1];
    rem_next = neg ? shifted[WIDTH:0] : diff[WIDTH:0];
    quo_next = {quo[WIDTH-2:0], ~neg};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; stalls the pipeline while iterating
// and holds sign-corrected HI/LO results in DONE until the execute stage moves on.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_en,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             stall_ext,
  output logic             div_stall,
  output logic             div_done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CntW = $clog2(WIDTH);

  div_state_t       state;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] divisor_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic [CntW-1:0]  cnt_q;

  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (divisor_q),
    .rem_next(rem_next),
    .quo_next(quo_next)
  );

  always_comb begin
    a_neg = div_signed & src_a[WIDTH-1];
    b_neg = div_signed & src_b[WIDTH-1];
    a_mag = a_neg ? -src_a : src_a;
    b_mag = b_neg ? -src_b : src_b;
    // Remainder follows the dividend sign; -2^31 / -1 falls out of plain truncation.
    q_fix = q_neg_q ? -quo_next : quo_next;
    r_fix = r_neg_q ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
  end

  assign div_stall = ~flush & (((state == IDLE) & div_en) | (state == CALC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      cnt_q     <= '0;
      div_done  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (flush) begin
      state    <= IDLE;
      div_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (div_en) begin
            q_neg_q   <= a_neg ^ b_neg;
            r_neg_q   <= a_neg;
            divisor_q <= b_mag;
            quo_q     <= a_mag;
            rem_q     <= '0;
            cnt_q     <= '0;
            if (src_b == '0) begin
              state     <= DONE;
              quotient  <= '1;
              remainder <= src_a;
              div_done  <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state     <= DONE;
            quotient  <= q_fix;
            remainder <= r_fix;
            div_done  <= 1'b1;
          end
        end
        DONE: begin
          // Instruction still sits in E while stalled elsewhere; a held div_en must not restart.
          if (!stall_ext) begin
            state    <= IDLE;
            div_done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random DIV/DIVU against a
// plain-arithmetic reference.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        div_en;
  logic        div_signed;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall_ext;
  logic        div_stall;
  logic        div_done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_vec;
  int n_err;

  div_unit #(
    .WIDTH(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .div_en    (div_en),
    .div_signed(div_signed),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .stall_ext (stall_ext),
    .div_stall (div_stall),
    .div_done  (div_done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Returns {quotient, remainder} from C-style truncating division.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint la;
    longint lb;
    longint q;
    longint r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (s) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
    end else begin
      la = longint'({32'd0, a});
      lb = longint'({32'd0, b});
    end
    q = la / lb;
    r = la % lb;
    return {q[31:0], r[31:0]};
  endfunction

  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s);
    logic [63:0] exp;
    int          stalls;
    int          cyc;
    int          lat;
    exp = ref_div(a, b, s);
    lat = (b == 32'd0) ? 1 : 33;
    @(negedge clk);
    div_en     = 1'b1;
    div_signed = s;
    src_a      = a;
    src_b      = b;
    stalls     = 0;
    cyc        = 0;
    #1;
    while (!div_done && cyc < 100) begin
      if (div_stall) stalls++;
      @(negedge clk);
      div_en = 1'b0;
      #1;
      cyc++;
    end
    check({tag, "_done"}, 32'(div_done), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(lat));
    check({tag, "_stalls"}, 32'(stalls), 32'(lat));
    check({tag, "_stall_in_done"}, 32'(div_stall), 32'd0);
    check({tag, "_quo"}, quotient, exp[63:32]);
    check({tag, "_rem"}, remainder, exp[31:0]);
    @(negedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(div_done), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q_prev;
    logic [31:0] r_prev;
    logic [63:0] exp;
    int          cyc;
    int          seen;

    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b1;
    div_en     = 1'b0;
    div_signed = 1'b0;
    src_a      = '0;
    src_b      = '0;
    flush      = 1'b0;
    stall_ext  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_quo", quotient, 32'd0);
    check("rst_rem", remainder, 32'd0);
    check("rst_done", 32'(div_done), 32'd0);
    check("rst_stall", 32'(div_stall), 32'd0);
    rst = 1'b0;

    do_div("divu_100_7", 32'd100, 32'd7, 1'b0);
    do_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    do_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
    do_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_div("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
    do_div("divu_dz", 32'h1234_5678, 32'd0, 1'b0);
    do_div("div_dz", 32'h8765_4321, 32'd0, 1'b1);

    // Directed values of the test plan, independent of the model.
    check("dir_m7_2_quo", ref_div(32'hFFFF_FFF9, 32'd2, 1'b1) >> 32, 32'hFFFF_FFFD);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 9));
        1:       b = 32'(-$urandom_range(1, 9));
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      do_div("rand", a, b, s);
    end

    // Flush during CALC: operation aborted, previous results untouched.
    q_prev = quotient;
    r_prev = remainder;
    @(negedge clk);
    div_en     = 1'b1;
    div_signed = 1'b0;
    src_a      = 32'd999;
    src_b      = 32'd3;
    repeat (11) begin
      @(negedge clk);
      div_en = 1'b0;
    end
    flush = 1'b1;
    #1;
    check("flush_stall_gated", 32'(div_stall), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_idle_stall", 32'(div_stall), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (div_done || div_stall) seen++;
      @(negedge clk);
      #1;
    end
    check("flush_no_done", 32'(seen), 32'd0);
    check("flush_quo_kept", quotient, q_prev);
    check("flush_rem_kept", remainder, r_prev);
    do_div("after_flush", 32'd999, 32'd3, 1'b0);

    // DONE held by stall_ext with div_en still asserted.
    exp = ref_div(32'hFFFF_FF00, 32'd5, 1'b1);
    @(negedge clk);
    stall_ext  = 1'b1;
    div_en     = 1'b1;
    div_signed = 1'b1;
    src_a      = 32'hFFFF_FF00;
    src_b      = 32'd5;
    cyc        = 0;
    #1;
    while (!div_done && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("hold_latency", 32'(cyc), 32'd33);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("hold_done", 32'(div_done), 32'd1);
      check("hold_no_restart", 32'(div_stall), 32'd0);
      check("hold_quo", quotient, exp[63:32]);
      check("hold_rem", remainder, exp[31:0]);
    end
    stall_ext = 1'b0;
    @(negedge clk);
    div_en = 1'b0;
    #1;
    check("hold_release_done", 32'(div_done), 32'd0);
    check("hold_release_stall", 32'(div_stall), 32'd0);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    div_en = 1'b1;
    src_a  = 32'd50;
    src_b  = 32'd6;
    repeat (6) begin
      @(negedge clk);
      div_en = 1'b0;
    end
    #1;
    check("pre_rst_stall", 32'(div_stall), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_stall", 32'(div_stall), 32'd0);
    check("arst_done", 32'(div_done), 32'd0);
    check("arst_quo", quotient, 32'd0);
    check("arst_rem", remainder, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_div("after_rst", 32'd50, 32'd6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
